xbar2x2_arbiter: RTL
====================

Name: xbar2x2_arbiter

Overview:
Control block for the 2x2 crossbar datapath. It arbitrates the two masters' requests for the two slaves and sequences each transfer. It drives the crossbar's mux selects and tristate enables, and the slave request/ack handshake. There is one independent FSM per slave, so m0->sX and m1->sY transfers run in parallel when X!=Y. Each slave has a round-robin pointer to resolve conflicts.

Parameters:
TIMEOUT, 16, max cycles in XFER without slave ack before the transfer is aborted (>=2)
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m0req, m1req  in  1  master request (level), held until mNack or mNerr
m0wr, m1wr  in  1  1=write, 0=read; stable while mNreq
m0sel, m1sel  in  1  target slave (0=s0, 1=s1); stable while mNreq
m0gnt, m1gnt  out  1  master owns a slave (ADDR..XFER)
m0ack, m1ack  out  1  transfer complete (combinational route of owning slave's ack)
m0err, m1err  out  1  one-cycle timeout pulse
s0req, s1req  out  1  slave access strobe (XFER state)
s0wr, s1wr  out  1  direction to slave
s0ack, s1ack  in  1  slave completion; read data valid on s*rw in the same cycle
muxs0addr, muxs1addr, muxs0, muxs1  out  1  1 selects m1 source toward slave
muxm0, muxm1  out  1  1 selects s1 source toward master
tris0, tris1, trim0, trim1  out  1  crossbar tristate enables

Behaviour:
- Reset: asynchronous. All outputs 0, both slave FSMs IDLE, RR pointers = 0 (m0 favoured), timeout counters 0. Reset mid-transfer aborts the transfer immediately with no ack/err.
- Per-slave FSM states: IDLE, ADDR, XFER. The state and owner (0/1) are registered. Mux/tri/req outputs are decoded from these registers, so they are glitch-free and change only on clk.
- IDLE: the candidates are the masters with mNreq=1, mNsel=this slave, and not currently owning the other slave.
  - One candidate: grant it.
  - Two candidates: grant the master indicated by the pointer, then set pointer = other master.
  - A single winner also sets pointer = other master.
  - On a grant, move to ADDR and latch the owner.
- ADDR (1 cycle): mNgnt=1. Addr and data muxes select the owner. No tri enables are asserted. This cycle lets the datapath address/write-data registers capture master values.
- XFER: sXreq=1, sXwr=owner's mNwr.
  - Write: trisX=1.
  - Read: trim[owner]=1, and muxm[owner] = X.
  - On sXack=1: m[owner]ack=1 the same cycle, and the FSM goes to IDLE next edge. The master samples read data on that edge.
  - If TIMEOUT cycles pass with no ack: pulse m[owner]err for 1 cycle, go to IDLE, no ack.
- A gnt-to-ack transfer takes a minimum of 2 cycles. Requesters get back-to-back grants with one IDLE cycle in between.
- Mux defaults when not in use are 0. muxmN is held at the slave index only while master N owns a slave.
- Invariants:
  - A master never owns both slaves.
  - trisX and trim[owner of X] are never both 1.
  - Each bus has at most one enabled driver.
- mNreq deasserting during ADDR/XFER is ignored; the transfer completes.
- sXack outside XFER is ignored.
- Masters must drive mNrw write data from gnt until ack, and must not drive mNrw during a read XFER.
- Both masters targeting different slaves in the same cycle: both are granted in the same cycle and proceed independently.

Test Plan:
- Reset: assert reset mid-XFER -> all outputs 0 within same cycle. After release with no requests, everything stays 0.
- Single write: m0req=1, m0wr=1, m0sel=1 -> next cycle m0gnt=1 (ADDR); cycle after, s1req=1, s1wr=1, tris1=1, muxs1=0, muxs1addr=0. s1ack at cycle 3 -> m0ack=1 same cycle, then idle.
- Single read: m1req=1, m1wr=0, m1sel=0 -> XFER has trim1=1, muxm1=0, s0wr=0, tris0=0. s0ack -> m1ack=1.
- Conflict: m0 and m1 both target s0, held continuously -> grant order m0, m1, m0, m1 with one IDLE cycle between grants.
- Parallel: m0->s1 write and m1->s0 read requested the same cycle -> both gnt together. s0req and s1req are both 1 with correct mux values and no conflicting tri.
- Timeout: m0 read of s0 with s0ack held 0 -> m0err pulses exactly TIMEOUT=16 cycles after XFER entry, trim0 drops, and a subsequent m1 request is granted.

Source files
------------

// File: rtl/xbar2x2_arbiter.sv
// 2x2 crossbar control: one arbitration/transfer FSM per slave, round-robin
// conflict resolution, with mux selects and tristate enables decoded from registered state.

module xbar_slave_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cand,   // eligible requesters, indexed by master
  input  logic [1:0] mwr,
  input  logic       sack,
  output logic       busy,
  output logic       xfer,
  output logic       owner,
  output logic       wr,
  output logic       ack,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, ADDR, XFER} st_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  st_t             st_q, st_d;
  logic            own_q, own_d, wr_q, wr_d, ptr_q, ptr_d, err_q, err_d, win;
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= IDLE;
      own_q <= 1'b0;
      wr_q  <= 1'b0;
      ptr_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      wr_q  <= wr_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    own_d = own_q;
    wr_d  = wr_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    win   = (cand == 2'b11) ? ptr_q : cand[1];
    case (st_q)
      IDLE: if (cand != 2'b00) begin
        own_d = win;
        wr_d  = mwr[win];
        ptr_d = ~win;
        st_d  = ADDR;
      end
      ADDR: begin
        cnt_d = '0;
        st_d  = XFER;
      end
      XFER: begin
        if (sack) st_d = IDLE;
        else if (cnt_q == TO_LAST) begin
          // err is registered so it shows as a clean pulse in the first IDLE cycle
          err_d = 1'b1;
          st_d  = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  assign busy  = (st_q != IDLE);
  assign xfer  = (st_q == XFER);
  assign owner = own_q;
  assign wr    = wr_q;
  assign ack   = xfer & sack;
  assign err   = err_q;
endmodule

module xbar2x2_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic m0req,
  input  logic m1req,
  input  logic m0wr,
  input  logic m1wr,
  input  logic m0sel,
  input  logic m1sel,
  output logic m0gnt,
  output logic m1gnt,
  output logic m0ack,
  output logic m1ack,
  output logic m0err,
  output logic m1err,
  output logic s0req,
  output logic s1req,
  output logic s0wr,
  output logic s1wr,
  input  logic s0ack,
  input  logic s1ack,
  output logic muxs0addr,
  output logic muxs1addr,
  output logic muxs0,
  output logic muxs1,
  output logic muxm0,
  output logic muxm1,
  output logic tris0,
  output logic tris1,
  output logic trim0,
  output logic trim1
);
  logic [1:0]      mreq, mwr, msel, sack;
  logic [1:0]      busy, xfer, owner, swr, sdone, serr;
  logic [1:0][1:0] cand, own, xown;   // [slave][master]
  logic [1:0]      mgnt, mack, merr, mtri;

  assign mreq = {m1req, m0req};
  assign mwr  = {m1wr, m0wr};
  assign msel = {m1sel, m0sel};
  assign sack = {s1ack, s0ack};

  for (genvar s = 0; s < 2; s++) begin : g_slv
    for (genvar m = 0; m < 2; m++) begin : g_m
      assign own[s][m]  = busy[s] && (owner[s] == 1'(m));
      assign xown[s][m] = own[s][m] && xfer[s];
      // a master already holding the other slave is not eligible here
      assign cand[s][m] = mreq[m] && (msel[m] == 1'(s)) && !own[1-s][m];
    end

    xbar_slave_fsm #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_fsm (
      .clk   (clk),
      .reset (reset),
      .cand  (cand[s]),
      .mwr   (mwr),
      .sack  (sack[s]),
      .busy  (busy[s]),
      .xfer  (xfer[s]),
      .owner (owner[s]),
      .wr    (swr[s]),
      .ack   (sdone[s]),
      .err   (serr[s])
    );
  end

  for (genvar m = 0; m < 2; m++) begin : g_mst
    assign mgnt[m] = own[0][m] | own[1][m];
    assign mack[m] = (sdone[0] && owner[0] == 1'(m)) || (sdone[1] && owner[1] == 1'(m));
    assign merr[m] = (serr[0] && owner[0] == 1'(m)) || (serr[1] && owner[1] == 1'(m));
    assign mtri[m] = (xown[0][m] && !swr[0]) || (xown[1][m] && !swr[1]);
  end

  assign {m1gnt, m0gnt} = mgnt;
  assign {m1ack, m0ack} = mack;
  assign {m1err, m0err} = merr;
  assign {trim1, trim0} = mtri;
  assign {s1req, s0req} = xfer;
  assign s0wr      = xfer[0] & swr[0];
  assign s1wr      = xfer[1] & swr[1];
  assign tris0     = xfer[0] & swr[0];
  assign tris1     = xfer[1] & swr[1];
  assign muxs0addr = busy[0] & owner[0];
  assign muxs1addr = busy[1] & owner[1];
  assign muxs0     = busy[0] & owner[0];
  assign muxs1     = busy[1] & owner[1];
  // master read mux points at s1 only while that master holds s1
  assign muxm0     = own[1][0];
  assign muxm1     = own[1][1];
endmodule
